// File: rtl/vblank_update_scheduler.sv
// Grants game-state update requests one at a time, round-robin, only during vertical blanking.
// Optional grant timeout enabled by defining VBSCHED_TIMEOUT_EN.
module vblank_update_scheduler #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned VB_ROW    = 480,
  parameter int unsigned MAX_GRANT = 2048
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  input  logic [9:0]      row,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] done,
  output logic [NREQ-1:0] gnt,
  output logic            frame_start,
  output logic            overrun,
  output logic            timeout,
  output logic [NREQ-1:0] skipped,
  output logic [15:0]     frame_count
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || MAX_GRANT < 2) begin : g_bad_param
    $error("vblank_update_scheduler: unsupported parameter value");
  end

  typedef enum logic [1:0] {StWaitVb, StArb, StGrant, StClosed} state_e;

  state_e          state_q;
  logic [9:0]      row_q;
  logic [NREQ-1:0] pending_q;
  logic [PW-1:0]   rr_ptr_q;
  logic [PW-1:0]   gnt_idx_q;

  logic            in_vb;
  logic            vb_entry;
  logic            done_hit;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   next_ptr;

  assign in_vb    = (row >= 10'(VB_ROW));
  assign vb_entry = (row == 10'(VB_ROW)) && (row_q != 10'(VB_ROW));
  assign done_hit = |(done & gnt);
  assign next_ptr = (gnt_idx_q == PW'(NREQ - 1)) ? '0 : gnt_idx_q + 1'b1;

  // Walk downward so the final assignment is the closest set bit at or after rr_ptr.
  always_comb begin
    pick_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pending_q[(int'(rr_ptr_q) + i) % NREQ]) begin
        pick_idx = PW'((int'(rr_ptr_q) + i) % NREQ);
      end
    end
  end

`ifdef VBSCHED_TIMEOUT_EN
  localparam int unsigned CW = $clog2(MAX_GRANT + 1);
  logic [CW-1:0] cnt_q;
  logic          cnt_expired;
  assign cnt_expired = (cnt_q == CW'(MAX_GRANT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q     <= StWaitVb;
      row_q       <= '0;
      pending_q   <= '0;
      rr_ptr_q    <= '0;
      gnt_idx_q   <= '0;
      gnt         <= '0;
      frame_start <= 1'b0;
      overrun     <= 1'b0;
      skipped     <= '0;
      frame_count <= '0;
`ifdef VBSCHED_TIMEOUT_EN
      timeout     <= 1'b0;
      cnt_q       <= '0;
`endif
    end else begin
      row_q       <= row;
      frame_start <= 1'b0;
      overrun     <= 1'b0;
`ifdef VBSCHED_TIMEOUT_EN
      timeout     <= 1'b0;
`endif
      unique case (state_q)
        StWaitVb: begin
          if (vb_entry) begin
            frame_start <= 1'b1;
            frame_count <= frame_count + 16'd1;
            pending_q   <= req;
            state_q     <= StArb;
          end
        end
        StArb: begin
          if (!in_vb) begin
            skipped <= pending_q;
            state_q <= StWaitVb;
          end else if (pending_q == '0) begin
            state_q <= StClosed;
          end else begin
            gnt           <= '0;
            gnt[pick_idx] <= 1'b1;
            gnt_idx_q     <= pick_idx;
            state_q       <= StGrant;
`ifdef VBSCHED_TIMEOUT_EN
            cnt_q         <= '0;
`endif
          end
        end
        StGrant: begin
          if (done_hit) begin
            pending_q[gnt_idx_q] <= 1'b0;
            rr_ptr_q             <= next_ptr;
            gnt                  <= '0;
            state_q              <= StArb;
`ifdef VBSCHED_TIMEOUT_EN
          end else if (cnt_expired) begin
            // Abandoned requester is dropped, so it never shows up in skipped.
            timeout              <= 1'b1;
            pending_q[gnt_idx_q] <= 1'b0;
            rr_ptr_q             <= next_ptr;
            gnt                  <= '0;
            state_q              <= StArb;
`endif
          end else if (!in_vb) begin
            overrun <= 1'b1;
            gnt     <= '0;
            skipped <= pending_q;
            state_q <= StWaitVb;
          end
`ifdef VBSCHED_TIMEOUT_EN
          if (!done_hit && !cnt_expired) begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        StClosed: begin
          if (!in_vb) begin
            skipped <= '0;
            state_q <= StWaitVb;
          end
        end
        default: state_q <= StWaitVb;
      endcase
    end
  end

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Directed self-checking bench for vblank_update_scheduler (NREQ=4, VB_ROW=480, MAX_GRANT=16).
module tb_vblank_update_scheduler;

  logic        clk;
  logic        reset;
  logic [9:0]  row;
  logic [3:0]  req;
  logic [3:0]  done;
  logic [3:0]  gnt;
  logic        frame_start;
  logic        overrun;
  logic        timeout;
  logic [3:0]  skipped;
  logic [15:0] frame_count;

  int total = 0;
  int bad   = 0;

  vblank_update_scheduler #(
    .NREQ      (4),
    .VB_ROW    (480),
    .MAX_GRANT (16)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .row         (row),
    .req         (req),
    .done        (done),
    .gnt         (gnt),
    .frame_start (frame_start),
    .overrun     (overrun),
    .timeout     (timeout),
    .skipped     (skipped),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_vb();
    row = 10'd479;
    step();
    row = 10'd480;
    step();
  endtask

  initial begin
    reset = 1'b0;
    row   = '0;
    req   = '0;
    done  = '0;
    step();
    step();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_fs", 32'(frame_start), 32'h0);
    check("rst_ovr", 32'(overrun), 32'h0);
    check("rst_to", 32'(timeout), 32'h0);
    check("rst_skip", 32'(skipped), 32'h0);
    check("rst_fc", 32'(frame_count), 32'h0);
    reset = 1'b1;
    step();

    // Frame 1: req 1011, done right after each grant.
    req = 4'b1011;
    enter_vb();
    check("f1_fs", 32'(frame_start), 32'h1);
    check("f1_fc", 32'(frame_count), 32'h1);
    check("f1_gnt_at_fs", 32'(gnt), 32'h0);
    row = 10'd481;
    step();
    check("f1_gnt0", 32'(gnt), 32'b0001);
    check("f1_fs_low", 32'(frame_start), 32'h0);
    done = 4'b0001; step(); done = '0;
    check("f1_idle", 32'(gnt), 32'h0);
    step();
    check("f1_gnt1", 32'(gnt), 32'b0010);
    done = 4'b0010; step(); done = '0;
    step();
    check("f1_gnt3", 32'(gnt), 32'b1000);
    done = 4'b1000; step(); done = '0;
    req = '0;
    step();
    row = 10'd0;
    step();
    check("f1_skip", 32'(skipped), 32'h0);
    check("f1_ovr", 32'(overrun), 32'h0);

    // Frames 2/3: req 1111, second grant never completes.
    req = 4'b1111;
    enter_vb();
    check("f2_fc", 32'(frame_count), 32'h2);
    row = 10'd490;
    step();
    check("f2_gnt0", 32'(gnt), 32'b0001);
    done = 4'b0001; step(); done = '0;
    step();
    check("f2_gnt1", 32'(gnt), 32'b0010);
    step();
    step();
    row = 10'd0;
    step();
    check("f2_ovr", 32'(overrun), 32'h1);
    check("f2_skip", 32'(skipped), 32'b1110);
    check("f2_gnt_drop", 32'(gnt), 32'h0);
    step();
    check("f2_ovr_pulse", 32'(overrun), 32'h0);

    enter_vb();
    check("f3_fc", 32'(frame_count), 32'h3);
    row = 10'd490;
    step();
    check("f3_gnt1", 32'(gnt), 32'b0010);
    done = 4'b0010; step(); done = '0;
    step();
    check("f3_gnt2", 32'(gnt), 32'b0100);
    row = 10'd0;
    step();
    check("f3_ovr", 32'(overrun), 32'h1);
    check("f3_skip", 32'(skipped), 32'b1101);

    // Frame 4: done coincides with blanking exit.
    req = 4'b0100;
    enter_vb();
    row = 10'd490;
    step();
    check("f4_gnt", 32'(gnt), 32'b0100);
    done = 4'b0100;
    row  = 10'd0;
    step();
    done = '0;
    req  = '0;
    check("f4_no_ovr", 32'(overrun), 32'h0);
    check("f4_gnt_off", 32'(gnt), 32'h0);
    step();
    check("f4_skip", 32'(skipped), 32'h0);

    // Frame 5: request after snapshot waits until frame 6.
    enter_vb();
    row = 10'd485;
    step();
    req = 4'b0100;
    step();
    check("f5_late_nognt", 32'(gnt), 32'h0);
    step();
    row = 10'd0;
    step();
    check("f5_skip", 32'(skipped), 32'h0);
    enter_vb();
    check("f6_fs", 32'(frame_start), 32'h1);
    row = 10'd481;
    step();
    check("f6_gnt", 32'(gnt), 32'b0100);

    // Asynchronous reset while granting.
    reset = 1'b0;
    #1;
    check("arst_gnt", 32'(gnt), 32'h0);
    check("arst_fc", 32'(frame_count), 32'h0);
    step();
    reset = 1'b1;
    req   = 4'b0011;
    step();
    enter_vb();
    check("post_rst_fc", 32'(frame_count), 32'h1);
    row = 10'd481;
    step();
    check("post_rst_gnt", 32'(gnt), 32'b0001);

`ifdef VBSCHED_TIMEOUT_EN
    repeat (15) step();
    check("to_before", 32'(timeout), 32'h0);
    check("to_hold", 32'(gnt), 32'b0001);
    step();
    check("to_pulse", 32'(timeout), 32'h1);
    check("to_gnt_off", 32'(gnt), 32'h0);
    step();
    check("to_next_gnt", 32'(gnt), 32'b0010);
    check("to_pulse_end", 32'(timeout), 32'h0);
    done = 4'b0010; step(); done = '0;
    req = '0;
    step();
    row = 10'd0;
    step();
    check("to_skip", 32'(skipped), 32'h0);
`else
    done = 4'b0001; step(); done = '0;
    step();
    check("post_rst_gnt1", 32'(gnt), 32'b0010);
    done = 4'b0010; step(); done = '0;
    req = '0;
    step();
    row = 10'd0;
    step();
    check("post_rst_skip", 32'(skipped), 32'h0);
    check("no_timeout", 32'(timeout), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
